mem_bus_arbiter: RTL and testbench

- Shares one single-beat memory port between the core's instruction bus (ibus) and data bus (dbus).
- Sits between the pipeline's fetch/memory stages and the memory/cache interface.
- Grants one requester at a time and latches the granted request.
- Forwards completion back as addr_ok/data_ok pulses; dbus has priority, bounded by an anti-starvation counter for ibus.

---
 rtl/mem_bus_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter sharing one single-beat memory port between the instruction bus and the
// data bus. The data bus has priority; a starvation counter guarantees the instruction bus progress.
module mem_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        ireq_valid,
  input  logic [63:0] ireq_addr,
  output logic        iaddr_ok,
  output logic        idata_ok,
  output logic [31:0] idata,

  input  logic        dreq_valid,
  input  logic [63:0] dreq_addr,
  input  logic [2:0]  dreq_size,
  input  logic [7:0]  dreq_strobe,
  input  logic [63:0] dreq_data,
  output logic        daddr_ok,
  output logic        ddata_ok,
  output logic [63:0] ddata,

  output logic        mreq_valid,
  output logic        mreq_is_write,
  output logic [63:0] mreq_addr,
  output logic [2:0]  mreq_size,
  output logic [7:0]  mreq_strobe,
  output logic [63:0] mreq_data,
  input  logic        mresp_ok,
  input  logic [63:0] mresp_data
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;

  localparam logic [CNT_W-1:0] StarveLimit = CNT_W'(STARVE_LIMIT);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic [63:0]      addr_q, addr_d;
  logic [2:0]       size_q, size_d;
  logic [7:0]       strobe_q, strobe_d;
  logic [63:0]      data_q, data_d;

  logic starved;
  logic grant_i, grant_d;
  logic done_i, done_d;

  assign starved = (starve_q >= StarveLimit);

  // Arbitration only happens in IDLE; requester inputs are ignored once a grant is made.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state_q == IDLE) begin
      if (dreq_valid && !(ireq_valid && starved)) begin
        grant_d = 1'b1;
      end else if (ireq_valid) begin
        grant_i = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    size_d   = size_q;
    strobe_d = strobe_q;
    data_d   = data_q;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d  = BUSY_D;
          addr_d   = dreq_addr;
          size_d   = dreq_size;
          strobe_d = dreq_strobe;
          data_d   = dreq_data;
        end else if (grant_i) begin
          state_d  = BUSY_I;
          addr_d   = ireq_addr;
          size_d   = 3'd2;
          strobe_d = 8'h00;
          data_d   = 64'h0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mresp_ok) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Counts data grants that overtook a waiting fetch; saturates rather than wrapping.
  always_comb begin
    starve_d = starve_q;
    if (grant_i) begin
      starve_d = '0;
    end else if (grant_d && ireq_valid && (starve_q != {CNT_W{1'b1}})) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      starve_q <= '0;
      addr_q   <= 64'h0;
      size_q   <= 3'd0;
      strobe_q <= 8'h00;
      data_q   <= 64'h0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      strobe_q <= strobe_d;
      data_q   <= data_d;
    end
  end

  assign done_i = (state_q == BUSY_I) && mresp_ok;
  assign done_d = (state_q == BUSY_D) && mresp_ok;

  assign mreq_valid    = (state_q == BUSY_I) || (state_q == BUSY_D);
  assign mreq_is_write = |strobe_q;
  assign mreq_addr     = addr_q;
  assign mreq_size     = size_q;
  assign mreq_strobe   = strobe_q;
  assign mreq_data     = data_q;

  assign iaddr_ok = done_i;
  assign idata_ok = done_i;
  assign idata    = done_i ? (addr_q[2] ? mresp_data[63:32] : mresp_data[31:0]) : 32'h0;

  assign daddr_ok = done_d;
  assign ddata_ok = done_d;
  assign ddata    = done_d ? mresp_data : 64'h0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: fetch-only, contention, starvation limit, latched writes,
// reset mid-transaction and stray responses in IDLE.
module tb_mem_bus_arbiter;

  logic        clk;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iaddr_ok, idata_ok;
  logic [31:0] idata;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        daddr_ok, ddata_ok;
  logic [63:0] ddata;
  logic        mreq_valid, mreq_is_write;
  logic [63:0] mreq_addr;
  logic [2:0]  mreq_size;
  logic [7:0]  mreq_strobe;
  logic [63:0] mreq_data;
  logic        mresp_ok;
  logic [63:0] mresp_data;

  int total = 0;
  int bad   = 0;

  mem_bus_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .ireq_valid   (ireq_valid),
    .ireq_addr    (ireq_addr),
    .iaddr_ok     (iaddr_ok),
    .idata_ok     (idata_ok),
    .idata        (idata),
    .dreq_valid   (dreq_valid),
    .dreq_addr    (dreq_addr),
    .dreq_size    (dreq_size),
    .dreq_strobe  (dreq_strobe),
    .dreq_data    (dreq_data),
    .daddr_ok     (daddr_ok),
    .ddata_ok     (ddata_ok),
    .ddata        (ddata),
    .mreq_valid   (mreq_valid),
    .mreq_is_write(mreq_is_write),
    .mreq_addr    (mreq_addr),
    .mreq_size    (mreq_size),
    .mreq_strobe  (mreq_strobe),
    .mreq_data    (mreq_data),
    .mresp_ok     (mresp_ok),
    .mresp_data   (mresp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here, checks follow a #1 settle.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset       = 1'b1;
    ireq_valid  = 1'b0;
    ireq_addr   = 64'h0;
    dreq_valid  = 1'b0;
    dreq_addr   = 64'h0;
    dreq_size   = 3'd0;
    dreq_strobe = 8'h00;
    dreq_data   = 64'h0;
    mresp_ok    = 1'b0;
    mresp_data  = 64'h0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    tick();
    #1;
    chk("rst_mreq_valid", 64'(mreq_valid), 64'd0);
    chk("rst_oks", 64'({iaddr_ok, idata_ok, daddr_ok, ddata_ok}), 64'd0);
    chk("rst_mreq_addr", mreq_addr, 64'h0);
    chk("rst_mreq_size", 64'(mreq_size), 64'd0);
    chk("rst_starve", 64'(dut.starve_q), 64'd0);

    // Fetch only, response two cycles after mreq_valid rises
    ireq_valid = 1'b1;
    ireq_addr  = 64'h8000_0004;
    #1;
    chk("i_grant_cycle_ok", 64'(iaddr_ok), 64'd0);
    chk("i_grant_cycle_mvalid", 64'(mreq_valid), 64'd0);
    tick();
    #1;
    chk("i_mreq_valid", 64'(mreq_valid), 64'd1);
    chk("i_mreq_addr", mreq_addr, 64'h8000_0004);
    chk("i_mreq_size", 64'(mreq_size), 64'd2);
    chk("i_mreq_strobe", 64'(mreq_strobe), 64'd0);
    chk("i_mreq_is_write", 64'(mreq_is_write), 64'd0);
    tick();
    #1;
    chk("i_wait_valid", 64'(mreq_valid), 64'd1);
    chk("i_wait_ok", 64'(idata_ok), 64'd0);
    tick();
    mresp_ok   = 1'b1;
    mresp_data = 64'h1111_2222_3333_4444;
    #1;
    chk("i_done_oks", 64'({iaddr_ok, idata_ok}), 64'b11);
    chk("i_done_idata", 64'(idata), 64'h1111_2222);
    chk("i_done_d_ok", 64'(ddata_ok), 64'd0);
    tick();
    ireq_valid = 1'b0;
    mresp_ok   = 1'b0;
    #1;
    chk("i_after_valid", 64'(mreq_valid), 64'd0);
    chk("i_after_ok", 64'(idata_ok), 64'd0);
    chk("i_after_idata", 64'(idata), 64'd0);

    // Simultaneous requests with an empty counter: dbus first, then ibus
    ireq_valid = 1'b1;
    ireq_addr  = 64'h1000;
    dreq_valid = 1'b1;
    dreq_addr  = 64'h2000;
    dreq_size  = 3'd3;
    tick();
    mresp_ok   = 1'b1;
    mresp_data = 64'hAAAA_BBBB_CCCC_DDDD;
    #1;
    chk("c_d_addr", mreq_addr, 64'h2000);
    chk("c_d_size", 64'(mreq_size), 64'd3);
    chk("c_d_oks", 64'({daddr_ok, ddata_ok, idata_ok}), 64'b110);
    chk("c_d_ddata", ddata, 64'hAAAA_BBBB_CCCC_DDDD);
    chk("c_starve_1", 64'(dut.starve_q), 64'd1);
    tick();
    dreq_valid = 1'b0;
    mresp_ok   = 1'b0;
    #1;
    chk("c_idle_valid", 64'(mreq_valid), 64'd0);
    chk("c_idle_ddata", ddata, 64'h0);
    tick();
    mresp_ok   = 1'b1;
    mresp_data = 64'h1234_5678_9ABC_DEF0;
    #1;
    chk("c_i_addr", mreq_addr, 64'h1000);
    chk("c_i_size", 64'(mreq_size), 64'd2);
    chk("c_i_idata", 64'(idata), 64'h9ABC_DEF0);
    chk("c_i_oks", 64'({iaddr_ok, idata_ok, ddata_ok}), 64'b110);
    chk("c_starve_0", 64'(dut.starve_q), 64'd0);
    tick();
    ireq_valid = 1'b0;
    mresp_ok   = 1'b0;

    // Starvation: four dbus wins, then ibus
    ireq_valid  = 1'b1;
    ireq_addr   = 64'h3004;
    dreq_valid  = 1'b1;
    dreq_addr   = 64'h40;
    dreq_size   = 3'd3;
    dreq_strobe = 8'h00;
    mresp_data  = 64'h5555_6666_7777_8888;
    for (int k = 0; k < 4; k++) begin
      tick();
      mresp_ok = 1'b1;
      #1;
      chk($sformatf("s_d%0d_ok", k), 64'({ddata_ok, idata_ok}), 64'b10);
      chk($sformatf("s_d%0d_addr", k), mreq_addr, 64'h40);
      chk($sformatf("s_d%0d_cnt", k), 64'(dut.starve_q), 64'(k + 1));
      tick();
      mresp_ok = 1'b0;
    end
    #1;
    chk("s_idle_valid", 64'(mreq_valid), 64'd0);
    tick();
    mresp_ok = 1'b1;
    #1;
    chk("s_i_oks", 64'({idata_ok, ddata_ok}), 64'b10);
    chk("s_i_addr", mreq_addr, 64'h3004);
    chk("s_i_idata", 64'(idata), 64'h5555_6666);
    chk("s_i_cnt", 64'(dut.starve_q), 64'd0);
    tick();
    ireq_valid = 1'b0;
    mresp_ok   = 1'b0;
    tick();
    mresp_ok = 1'b1;
    #1;
    chk("s_d_alone_ok", 64'(ddata_ok), 64'd1);
    chk("s_d_alone_cnt", 64'(dut.starve_q), 64'd0);
    tick();
    dreq_valid = 1'b0;
    mresp_ok   = 1'b0;

    // Latched write, requester inputs changed and dropped during BUSY
    dreq_valid  = 1'b1;
    dreq_addr   = 64'h100;
    dreq_size   = 3'd3;
    dreq_strobe = 8'hFF;
    dreq_data   = 64'hDEAD_BEEF_0000_0001;
    tick();
    dreq_data   = 64'h0;
    dreq_addr   = 64'h999;
    dreq_strobe = 8'h01;
    #1;
    chk("w_is_write", 64'(mreq_is_write), 64'd1);
    chk("w_data", mreq_data, 64'hDEAD_BEEF_0000_0001);
    chk("w_addr", mreq_addr, 64'h100);
    chk("w_strobe", 64'(mreq_strobe), 64'hFF);
    tick();
    dreq_valid = 1'b0;
    #1;
    chk("w_hold_valid", 64'(mreq_valid), 64'd1);
    chk("w_hold_data", mreq_data, 64'hDEAD_BEEF_0000_0001);
    tick();
    mresp_ok   = 1'b1;
    mresp_data = 64'h0;
    #1;
    chk("w_done_oks", 64'({daddr_ok, ddata_ok}), 64'b11);
    tick();
    mresp_ok    = 1'b0;
    dreq_strobe = 8'h00;
    #1;
    chk("w_after_valid", 64'(mreq_valid), 64'd0);

    // Reset while BUSY_D
    ireq_valid = 1'b1;
    ireq_addr  = 64'h500;
    dreq_valid = 1'b1;
    dreq_addr  = 64'h200;
    tick();
    #1;
    chk("r_busy_valid", 64'(mreq_valid), 64'd1);
    chk("r_busy_cnt", 64'(dut.starve_q), 64'd1);
    reset = 1'b1;
    tick();
    reset      = 1'b0;
    ireq_valid = 1'b0;
    dreq_valid = 1'b0;
    #1;
    chk("r_after_valid", 64'(mreq_valid), 64'd0);
    chk("r_after_cnt", 64'(dut.starve_q), 64'd0);
    chk("r_after_addr", mreq_addr, 64'h0);
    tick();
    mresp_ok   = 1'b1;
    mresp_data = 64'hFFFF_0000_FFFF_0000;
    #1;
    chk("r_late_oks", 64'({iaddr_ok, idata_ok, daddr_ok, ddata_ok}), 64'd0);
    chk("r_late_ddata", ddata, 64'h0);

    // Stray response in IDLE
    tick();
    #1;
    chk("x_idle_oks", 64'({iaddr_ok, idata_ok, daddr_ok, ddata_ok}), 64'd0);
    chk("x_idle_idata", 64'(idata), 64'd0);
    tick();
    mresp_ok = 1'b0;
    #1;
    chk("x_idle_valid", 64'(mreq_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
